conv_job_sequencer: RTL

- Top-level job controller for the convolution core.
- Gates host writes into the X/Y operand memories and validates the job sizes.
- Launches the core and supervises it with a watchdog.
- Streams the sizeX+sizeY-1 result words out of memZ over a valid/ready interface, and reports sticky done/error status to the host register block.

---
 rtl/conv_job_sequencer_pkg.sv | 23 ++
 rtl/conv_job_sequencer_if.sv | 12 +
 rtl/conv_job_sequencer_watchdog.sv | 29 ++
 rtl/conv_job_sequencer.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/conv_job_sequencer_pkg.sv
// Shared types and helpers for the convolution job sequencer.
package conv_seq_pkg;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_ADDR_WIDTH = 5;
   localparam int ZADDR_WIDTH    = DEF_ADDR_WIDTH + 1;
   localparam int RES_WIDTH      = 2 * DEF_DATA_WIDTH;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LAUNCH,
      S_RUN,
      S_DRAIN_RD,
      S_DRAIN_OUT,
      S_FLUSH
   } seq_state_t;

   // Number of result words a job produces.
   function automatic logic [31:0] zlen(input logic [31:0] sx, input logic [31:0] sy);
      return sx + sy - 32'd1;
   endfunction

endpackage

// File: rtl/conv_job_sequencer_if.sv
// Result stream from the sequencer to its consumer (valid/ready with last marker).
interface conv_res_if import conv_seq_pkg::*; #(
   parameter int WIDTH = RES_WIDTH
);
   logic             valid;
   logic             ready;
   logic [WIDTH-1:0] data;
   logic             last;

   modport master (output valid, output data, output last, input ready);
   modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/conv_job_sequencer_watchdog.sv
// RUN-phase watchdog: down-counter reloaded on clear, terminal count at zero.
module conv_seq_watchdog #(
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic clk,
   input  logic rstn,
   input  logic clr,
   input  logic en,
   output logic tc
);
   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= LOAD_VAL;
      end else if (en && (cnt != '0)) begin
         cnt <= cnt - CW'(1);
      end
   end

   // Reaching zero after LOAD_VAL decrements equals TIMEOUT_CYCLES enabled cycles.
   assign tc = (cnt == '0);

endmodule

// File: rtl/conv_job_sequencer.sv
// Job controller for the convolution core: operand write gating, launch,
// watchdog supervision, result drain and sticky host status.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | host owns X/Y memories; waits for a start with valid sizes
// S_LAUNCH    | one-cycle core start pulse, watchdog reload
// S_RUN       | core computing; watchdog counting
// S_DRAIN_RD  | memZ read address presented
// S_DRAIN_OUT | capture read data, then hold it until the consumer takes it
// S_FLUSH     | error/abort recovery; waits for the core to go idle
module conv_job_sequencer import conv_seq_pkg::*; #(
   parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic [ADDR_WIDTH-1:0]   cfg_size_x_i,
   input  logic [ADDR_WIDTH-1:0]   cfg_size_y_i,
   input  logic                    cfg_start_i,
   input  logic                    cfg_abort_i,
   input  logic                    clr_status_i,
   input  logic                    host_wr_en_i,
   input  logic                    host_wr_sel_i,
   input  logic [ADDR_WIDTH-1:0]   host_wr_addr_i,
   input  logic [DATA_WIDTH-1:0]   host_wr_data_i,
   output logic [ADDR_WIDTH-1:0]   mem_wr_addr_o,
   output logic [DATA_WIDTH-1:0]   mem_wr_data_o,
   output logic                    memX_we_o,
   output logic                    memY_we_o,
   output logic [2*ADDR_WIDTH-1:0] core_config_o,
   output logic                    core_start_o,
   input  logic                    core_busy_i,
   input  logic                    core_done_i,
   output logic [ADDR_WIDTH:0]     memZ_rd_addr_o,
   input  logic [2*DATA_WIDTH-1:0] memZ_rd_data_i,
   conv_res_if.master              res,
   output logic                    busy_o,
   output logic                    done_o,
   output logic                    err_o
);
   localparam int ZW = ADDR_WIDTH + 1;

   seq_state_t          state;
   logic [ZW-1:0]       remaining;
   logic                wd_tc;
   logic                abort_hit;
   logic                size_bad;
   logic [ADDR_WIDTH-1:0] size_x_q;
   logic [ADDR_WIDTH-1:0] size_y_q;

   assign size_x_q = core_config_o[ADDR_WIDTH-1:0];
   assign size_y_q = core_config_o[2*ADDR_WIDTH-1:ADDR_WIDTH];
   assign size_bad = (cfg_size_x_i == '0) || (cfg_size_y_i == '0);

   assign abort_hit = cfg_abort_i &&
                      (state inside {S_LAUNCH, S_RUN, S_DRAIN_RD, S_DRAIN_OUT});

   // The core owns the operand memories outside IDLE, so host writes are dropped.
   assign mem_wr_addr_o = host_wr_addr_i;
   assign mem_wr_data_o = host_wr_data_i;
   assign memX_we_o     = (state == S_IDLE) && host_wr_en_i && !host_wr_sel_i;
   assign memY_we_o     = (state == S_IDLE) && host_wr_en_i &&  host_wr_sel_i;
   assign busy_o        = (state != S_IDLE);

   conv_seq_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk  (clk),
      .rstn (rstn),
      .clr  (state == S_LAUNCH),
      .en   (state == S_RUN),
      .tc   (wd_tc)
   );

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state          <= S_IDLE;
         core_config_o  <= '0;
         core_start_o   <= 1'b0;
         memZ_rd_addr_o <= '0;
         remaining      <= '0;
         res.valid      <= 1'b0;
         res.data       <= '0;
         res.last       <= 1'b0;
         done_o         <= 1'b0;
         err_o          <= 1'b0;
      end else begin
         core_start_o <= 1'b0;

         // Later set events in this block override the clear.
         if (clr_status_i) begin
            done_o <= 1'b0;
            err_o  <= 1'b0;
         end

         if (abort_hit) begin
            err_o     <= 1'b1;
            res.valid <= 1'b0;
            res.last  <= 1'b0;
            state     <= core_busy_i ? S_FLUSH : S_IDLE;
         end else begin
            case (state)
               S_IDLE: begin
                  if (cfg_start_i) begin
                     core_config_o <= {cfg_size_y_i, cfg_size_x_i};
                     done_o        <= 1'b0;
                     err_o         <= 1'b0;
                     if (size_bad) begin
                        err_o <= 1'b1;
                     end else begin
                        core_start_o <= 1'b1;
                        state        <= S_LAUNCH;
                     end
                  end
               end
               S_LAUNCH: begin
                  state <= S_RUN;
               end
               S_RUN: begin
                  if (core_done_i) begin
                     memZ_rd_addr_o <= '0;
                     remaining      <= ZW'(zlen(32'(size_x_q), 32'(size_y_q)));
                     state          <= S_DRAIN_RD;
                  end else if (wd_tc) begin
                     err_o <= 1'b1;
                     state <= S_FLUSH;
                  end
               end
               S_DRAIN_RD: begin
                  state <= S_DRAIN_OUT;
               end
               S_DRAIN_OUT: begin
                  // First cycle here sees the read data; afterwards hold until taken.
                  if (!res.valid) begin
                     res.data  <= memZ_rd_data_i;
                     res.valid <= 1'b1;
                     res.last  <= (remaining == ZW'(1));
                  end else if (res.ready) begin
                     res.valid <= 1'b0;
                     res.last  <= 1'b0;
                     if (res.last) begin
                        done_o <= 1'b1;
                        state  <= S_IDLE;
                     end else begin
                        memZ_rd_addr_o <= memZ_rd_addr_o + ZW'(1);
                        remaining      <= remaining - ZW'(1);
                        state          <= S_DRAIN_RD;
                     end
                  end
               end
               S_FLUSH: begin
                  if (!core_busy_i) begin
                     state <= S_IDLE;
                  end
               end
               default: begin
                  state <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule
